// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter.
//
// Takes a WIDTH-bit word over a valid/ready handshake. It then sends the word
// one bit per enabled clock on data_out. busy frames the bits so the
// receiver's shift_en can follow it. done pulses for one cycle once the last
// bit of the frame has been consumed.
//
// Optional feature macro: PISO_PARITY_EN
//   When this macro is defined, the frame carries one extra bit after the
//   data bits: the even parity (XOR) of the loaded word.
//
// Parameters
//   WIDTH      word width in bits (2 or more)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   clr         synchronous clear, active high; overrides load and shift
//   load_valid  producer offers data_in
//   load_ready  transmitter can accept a word (idle)
//   data_in     parallel word
//   shift_en    advance to the next serial bit
//   data_out    current serial bit (registered; 0 when idle)
//   busy        a frame is in progress
//   done        one-cycle pulse after the final bit was consumed
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             data_out,
  output logic             busy,
  output logic             done
);

  // One spare bit keeps WIDTH-1 representable for any WIDTH. The counter is
  // reloaded before it can ever wrap.
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_e;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             done_q, done_d;
  logic             last_bit;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments. All flops then update
  // together, so the order of the sequential blocks does not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational output gets a default before any branch. A path
  // that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (load_valid) state_d = SHIFT;
`ifdef PISO_PARITY_EN
        SHIFT:  if (shift_en && last_bit) state_d = PARITY;
        PARITY: if (shift_en) state_d = IDLE;
`else
        SHIFT:  if (shift_en && last_bit) state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: shift register, bit counter, done, serial bit
  // ---------------------------------------------------------------------------
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
`ifdef PISO_PARITY_EN
    par_d  = par_q;
`endif
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
`ifdef PISO_PARITY_EN
      par_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            sreg_d = data_in;
            cnt_d  = '0;
`ifdef PISO_PARITY_EN
            // Parity comes from the loaded word, not the draining register.
            par_d  = ^data_in;
`endif
          end
        end
        SHIFT: begin
          if (shift_en) begin
            // Zero-fill: the register is empty after the last data bit.
            sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            if (last_bit) begin
              cnt_d  = '0;
`ifndef PISO_PARITY_EN
              done_d = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: if (shift_en) done_d = 1'b1;
`endif
        default: ;
      endcase
    end

    // data_out is computed from the next state. The serial line then comes
    // straight from a flop and cannot glitch.
    case (state_d)
      SHIFT:   dout_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
`ifdef PISO_PARITY_EN
      PARITY:  dout_d = par_d;
`endif
      default: dout_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
      done_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      done_q <= done_d;
`ifdef PISO_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q != IDLE);
    data_out   = dout_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx. Two instances share every input: one sends MSB
// first, the other LSB first. A bit-queue reference model predicts both
// serial streams together with busy, done and load_ready.
module tb_piso_tx;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             load_valid;
  logic             shift_en;
  logic [WIDTH-1:0] data_in;
  logic             load_ready_m, data_out_m, busy_m, done_m;
  logic             load_ready_l, data_out_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst_n), .clr(clr), .load_valid(load_valid),
    .load_ready(load_ready_m), .data_in(data_in), .shift_en(shift_en),
    .data_out(data_out_m), .busy(busy_m), .done(done_m)
  );

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst_n), .clr(clr), .load_valid(load_valid),
    .load_ready(load_ready_l), .data_in(data_in), .shift_en(shift_en),
    .data_out(data_out_l), .busy(busy_l), .done(done_l)
  );

  // ---------------------------------------------------------------------------
  // Reference model. Each queue holds the bits of a frame that are still to
  // be sent. The head of the queue is the bit on the line now. An empty
  // queue means the transmitter is idle.
  // ---------------------------------------------------------------------------
  bit   q_m[$];
  bit   q_l[$];
  logic done_e = 1'b0;

  function automatic void model_reset();
    q_m.delete();
    q_l.delete();
    done_e = 1'b0;
  endfunction

  function automatic void model_edge(input logic lv, input logic [WIDTH-1:0] d,
                                     input logic se, input logic c);
    done_e = 1'b0;
    if (c) begin
      q_m.delete();
      q_l.delete();
    end else if (q_m.size() == 0) begin
      if (lv) begin
        for (int i = WIDTH - 1; i >= 0; i--) q_m.push_back(d[i]);
        for (int i = 0; i < WIDTH; i++) q_l.push_back(d[i]);
`ifdef PISO_PARITY_EN
        q_m.push_back(^d);
        q_l.push_back(^d);
`endif
      end
    end else if (se) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
      if (q_m.size() == 0) done_e = 1'b1;
    end
  endfunction

  function automatic logic [7:0] exp_vec();
    logic b;
    b = (q_m.size() != 0);
    return {b ? q_m[0] : 1'b0, b, done_e, ~b, b ? q_l[0] : 1'b0, b, done_e, ~b};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {data_out_m, busy_m, done_m, load_ready_m,
            data_out_l, busy_l, done_l, load_ready_l};
  endfunction

  // Drive the inputs for one clock. Step the model on the edge, then return
  // 1 ns later, when the outputs have settled.
  task automatic cycle(input logic lv, input logic [WIDTH-1:0] d,
                       input logic se, input logic c);
    load_valid = lv;
    data_in    = d;
    shift_en   = se;
    clr        = c;
    @(posedge clk);
    model_edge(lv, d, se, c);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; load_valid = 1'b1; data_in = 8'hFF; shift_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_vec() !== 8'b0001_0001) begin
      n_fail++;
      $display("FAIL reset_state got %b exp %b", obs_vec(), 8'b0001_0001);
    end
    model_reset();
    load_valid = 1'b0; shift_en = 1'b0;
    #2 rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got %b exp %b", obs_vec(), exp_vec());
    end
  endtask

  // Frame with continuous shift_en. The MSB instance must rebuild word_m and
  // the LSB instance must rebuild word_l.
  task automatic test_frame(input logic [WIDTH-1:0] word, input string name);
    logic [WIDTH-1:0] rx_m, rx_l;
    int done_cnt, done_at;
    rx_m = '0; rx_l = '0; done_cnt = 0; done_at = -1;
    for (int k = 0; k <= FRAME_LEN + 1; k++) begin
      cycle(k == 0, word, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s k=%0d got %b exp %b", name, k, obs_vec(), exp_vec());
      end
      if (k < WIDTH) begin
        rx_m = {rx_m[WIDTH-2:0], data_out_m};
        rx_l = {data_out_l, rx_l[WIDTH-1:1]};
      end
      if (done_m) begin
        done_cnt++;
        done_at = k;
      end
    end
    n_checks++;
    if (rx_m !== word) begin
      n_fail++;
      $display("FAIL %s_msb_word got %h exp %h", name, rx_m, word);
    end
    n_checks++;
    if (rx_l !== word) begin
      n_fail++;
      $display("FAIL %s_lsb_word got %h exp %h", name, rx_l, word);
    end
    n_checks++;
    if (done_cnt !== 1 || done_at !== FRAME_LEN) begin
      n_fail++;
      $display("FAIL %s_done got cnt=%0d at=%0d exp cnt=1 at=%0d", name, done_cnt, done_at, FRAME_LEN);
    end
    n_checks++;
    if (busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_after got %b exp 0", name, busy_m);
    end
  endtask

  // F0: three shifts, five stall cycles, then continue. A load offered during
  // the frame must be ignored.
  task automatic test_stall();
    int done_cnt, done_at;
    done_cnt = 0; done_at = -1;
    for (int k = 0; k <= FRAME_LEN + 7; k++) begin
      cycle(k == 0 || k == 6, (k == 6) ? 8'h0F : 8'hF0, !(k >= 4 && k <= 8), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      // After three shifts the head is bit 4 of F0 (1). It must hold there.
      if (k >= 3 && k <= 8) begin
        n_checks++;
        if (data_out_m !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold k=%0d got %b exp 1", k, data_out_m);
        end
      end
      if (done_m) begin
        done_cnt++;
        done_at = k;
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_at !== FRAME_LEN + 5) begin
      n_fail++;
      $display("FAIL stall_done got cnt=%0d at=%0d exp cnt=1 at=%0d", done_cnt, done_at, FRAME_LEN + 5);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*FRAME_LEN-1:0] stream, expect_s;
    int n_bits, accept2, gap, done_cnt;
    logic prev_busy;
`ifdef PISO_PARITY_EN
    expect_s = 18'b001111000_110000110;
`else
    expect_s = 16'b00111100_11000011;
`endif
    stream = '0; n_bits = 0; accept2 = -1; gap = 0; done_cnt = 0; prev_busy = 1'b0;
    for (int k = 0; k <= 2 * FRAME_LEN + 2; k++) begin
      if (k == 0) cycle(1'b1, 8'h3C, 1'b1, 1'b0);
      else        cycle(accept2 < 0, 8'hC3, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b k=%0d got %b exp %b", k, obs_vec(), exp_vec());
      end
      if (busy_m) begin
        stream = {stream[2*FRAME_LEN-2:0], data_out_m};
        n_bits++;
      end
      if (k > 0 && busy_m && !prev_busy && accept2 < 0) accept2 = k;
      if (k > 0 && !busy_m && accept2 < 0) gap++;
      if (done_m) done_cnt++;
      prev_busy = busy_m;
    end
    n_checks++;
    if (n_bits !== 2 * FRAME_LEN || stream !== expect_s) begin
      n_fail++;
      $display("FAIL b2b_stream got %b (%0d bits) exp %b", stream, n_bits, expect_s);
    end
    n_checks++;
    if (accept2 !== FRAME_LEN + 1 || gap !== 1 || done_cnt !== 2) begin
      n_fail++;
      $display("FAIL b2b_timing got accept=%0d gap=%0d done=%0d exp %0d 1 2", accept2, gap, done_cnt, FRAME_LEN + 1);
    end
  endtask

  task automatic test_abort();
    // clr after the fourth bit of FF.
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b1);
    n_checks++;
    if (obs_vec() !== 8'b0001_0001 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL clr_abort got %b exp %b", obs_vec(), 8'b0001_0001);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (done_m !== 1'b0 || done_l !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_done got %b%b exp 00", done_m, done_l);
    end
    // clr on the very edge that would have finished the frame.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < FRAME_LEN - 1; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (obs_vec() !== 8'b0001_0001) begin
      n_fail++;
      $display("FAIL clr_last_edge got %b exp %b", obs_vec(), 8'b0001_0001);
    end
    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== 8'b0001_0001) begin
      n_fail++;
      $display("FAIL rst_abort got %b exp %b", obs_vec(), 8'b0001_0001);
    end
    model_reset();
    load_valid = 1'b1; data_in = 8'hFF;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs_vec() !== 8'b0001_0001) begin
      n_fail++;
      $display("FAIL rst_held got %b exp %b", obs_vec(), 8'b0001_0001);
    end
    load_valid = 1'b0;
    #1 rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL rst_release got %b exp %b", obs_vec(), exp_vec());
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity(input logic [WIDTH-1:0] word, input logic par);
    for (int k = 0; k <= FRAME_LEN; k++) begin
      cycle(k == 0, word, 1'b1, 1'b0);
      if (k == WIDTH) begin
        n_checks++;
        if (data_out_m !== par || data_out_l !== par || busy_m !== 1'b1) begin
          n_fail++;
          $display("FAIL parity_bit word=%h got %b%b busy=%b exp %b", word, data_out_m, data_out_l, busy_m, par);
        end
      end
      if (k == FRAME_LEN) begin
        n_checks++;
        if (done_m !== 1'b1 || busy_m !== 1'b0) begin
          n_fail++;
          $display("FAIL parity_done word=%h got done=%b busy=%b exp 1 0", word, done_m, busy_m);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) < 4, WIDTH'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 59) == 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random i=%0d got %b exp %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, "frame_a5");
    test_frame(8'hB1, "frame_b1");
    test_stall();
    test_back_to_back();
    test_abort();
`ifdef PISO_PARITY_EN
    test_parity(8'hA5, 1'b0);
    test_parity(8'h07, 1'b1);
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
